// File: rtl/alu_pkg.sv
// Shared defaults and FSM state type for the ALU arbiter.
package alu_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves to the loser on update.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Granting requester 0 hands priority to requester 1, and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= 1'b0;
    else if (update && (gnt != 2'b00))
      ptr <= gnt[0];
  end
endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU, one op per 3 cycles.
// Handshake: a requester holds req until its one-cycle gnt pulse; done marks res_* valid.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic              cin0,
  input  logic              cin1,
  input  logic [SEL_W-1:0]  sel0,
  input  logic [SEL_W-1:0]  sel1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_cin,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_sum,
  input  logic [DATA_W-1:0] alu_mult,
  input  logic              alu_cout,
  input  logic              alu_flag,
  output logic              done,
  output logic              done_id,
  output logic [DATA_W-1:0] res_sum,
  output logic [DATA_W-1:0] res_mult,
  output logic              res_cout,
  output logic              res_flag,
  output logic              busy,
  output logic [1:0]        state_dbg
);
  state_t            state, state_nxt;
  logic              accept;
  logic [1:0]        arb_gnt;
  logic              win_id;
  logic [DATA_W-1:0] op_a, op_b;
  logic              op_cin;
  logic [SEL_W-1:0]  op_sel;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1, req0}),
    .update (accept),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (req0 || req1) begin
        accept    = 1'b1;
        state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands latch on acceptance; results and owner latch at the end of EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_id   <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      op_sel   <= '0;
      done_id  <= 1'b0;
      res_sum  <= '0;
      res_mult <= '0;
      res_cout <= 1'b0;
      res_flag <= 1'b0;
    end else begin
      if (accept) begin
        win_id <= arb_gnt[1];
        op_a   <= arb_gnt[1] ? a1   : a0;
        op_b   <= arb_gnt[1] ? b1   : b0;
        op_cin <= arb_gnt[1] ? cin1 : cin0;
        op_sel <= arb_gnt[1] ? sel1 : sel0;
      end
      if (state == EXEC) begin
        done_id  <= win_id;
        res_sum  <= alu_sum;
        res_mult <= alu_mult;
        res_cout <= alu_cout;
        res_flag <= alu_flag;
      end
    end
  end

  assign gnt0      = (state == EXEC) && !win_id;
  assign gnt1      = (state == EXEC) &&  win_id;
  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_cin   = op_cin;
  assign alu_sel   = (state == EXEC) ? op_sel : '0;
  assign done      = (state == RESP);
  assign busy      = (state != IDLE);
  assign state_dbg = state;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stub, transaction-level model checked every cycle, directed vectors.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 0, req1 = 0, cin0 = 0, cin1 = 0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [S-1:0] sel0 = '0, sel1 = '0;
  logic         gnt0, gnt1, alu_cin, alu_cout, alu_flag;
  logic [W-1:0] alu_a, alu_b, alu_sum, alu_mult;
  logic [S-1:0] alu_sel;
  logic         done, done_id, res_cout, res_flag, busy;
  logic [W-1:0] res_sum, res_mult;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(W), .SEL_W(S)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cin0(cin0), .cin1(cin1), .sel0(sel0), .sel1(sel1),
    .gnt0(gnt0), .gnt1(gnt1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
    .alu_sum(alu_sum), .alu_mult(alu_mult), .alu_cout(alu_cout), .alu_flag(alu_flag),
    .done(done), .done_id(done_id),
    .res_sum(res_sum), .res_mult(res_mult), .res_cout(res_cout), .res_flag(res_flag),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ALU stub
  assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
  assign alu_mult = alu_a * alu_b;
  assign alu_flag = alu_sum[W-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // m_left counts cycles of the current operation still to come: 2 = granted, 1 = responding.
  int           m_left = 0;
  logic         m_prio = 0, m_win = 0, m_done_id = 0, m_cin = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [S-1:0] m_sel = '0;
  logic [W:0]   m_sum = '0;
  logic [W-1:0] m_mult = '0;

  function automatic logic pick(input logic r0, input logic r1, input logic prio);
    if (r0 && r1) return prio;
    return r1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_prio <= 0; m_win <= 0; m_done_id <= 0;
      m_a <= '0; m_b <= '0; m_cin <= 0; m_sel <= '0;
      m_sum <= '0; m_mult <= '0;
    end else if (m_left == 0) begin
      if (req0 || req1) begin
        m_left <= 2;
        m_win  <= pick(req0, req1, m_prio);
        m_prio <= !pick(req0, req1, m_prio);
        m_a    <= pick(req0, req1, m_prio) ? a1 : a0;
        m_b    <= pick(req0, req1, m_prio) ? b1 : b0;
        m_cin  <= pick(req0, req1, m_prio) ? cin1 : cin0;
        m_sel  <= pick(req0, req1, m_prio) ? sel1 : sel0;
      end
    end else begin
      if (m_left == 2) begin
        m_sum     <= {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_cin);
        m_mult    <= W'(64'(m_a) * 64'(m_b));
        m_done_id <= m_win;
      end
      m_left <= m_left - 1;
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt0",     gnt0,     (m_left == 2) && !m_win);
      chk("gnt1",     gnt1,     (m_left == 2) &&  m_win);
      chk("done",     done,     m_left == 1);
      chk("busy",     busy,     m_left != 0);
      chk("done_id",  done_id,  m_done_id);
      chk("res_sum",  res_sum,  m_sum[W-1:0]);
      chk("res_cout", res_cout, m_sum[W]);
      chk("res_flag", res_flag, m_sum[W-1]);
      chk("res_mult", res_mult, m_mult);
      chk("alu_a",    alu_a,    m_a);
      chk("alu_b",    alu_b,    m_b);
      chk("alu_cin",  alu_cin,  m_cin);
      chk("alu_sel",  alu_sel,  (m_left == 2) ? m_sel : '0);
      if (gnt0 && gnt1) chk("gnt_onehot", 1, 0);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [0:0] exp_q[$];
  int         last_done;
  int         n_grants;

  initial begin
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt1, gnt0}, 0);
    chk("rst_res_sum", res_sum, 0);
    chk("rst_alu_a", alu_a, 0);
    rst = 1'b0;

    // single request from requester 0
    req0 = 1; a0 = 5; b0 = 7; cin0 = 1; sel0 = 1;
    tick();
    chk("t1_gnt0", gnt0, 1);
    chk("t1_alu_sel", alu_sel, 1);
    req0 = 0;
    tick();
    chk("t1_done", done, 1);
    chk("t1_done_id", done_id, 0);
    chk("t1_sum", res_sum, 13);
    chk("t1_mult", res_mult, 35);
    chk("t1_cout", res_cout, 0);
    tick();

    // operands change during EXEC; sel 15 passes through only in EXEC
    req0 = 1; a0 = 3; b0 = 4; cin0 = 0; sel0 = 15;
    tick();
    chk("t2_alu_sel_exec", alu_sel, 15);
    a0 = 99; req0 = 0;
    tick();
    chk("t2_sum", res_sum, 7);
    chk("t2_mult", res_mult, 12);
    chk("t2_alu_sel_resp", alu_sel, 0);

    // req raised during RESP is not taken until IDLE; wrap-around operands
    req1 = 1; a1 = 32'hFFFF_FFFF; b1 = 1; cin1 = 0; sel1 = 9;
    tick();
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_gnt1", gnt1, 0);
    tick();
    chk("t3_gnt1", gnt1, 1);
    req1 = 0;
    tick();
    chk("t3_sum", res_sum, 0);
    chk("t3_cout", res_cout, 1);
    chk("t3_flag", res_flag, 0);
    chk("t3_mult", res_mult, 32'hFFFF_FFFF);
    chk("t3_done_id", done_id, 1);
    tick();

    // reset during EXEC aborts the operation
    req0 = 1; a0 = 10; b0 = 20; cin0 = 0; sel0 = 3;
    tick();
    req0 = 0;
    rst = 1;
    #1;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_res_sum", res_sum, 0);
    tick();
    rst = 0;
    req1 = 1; a1 = 2; b1 = 3; cin1 = 0; sel1 = 2;
    tick();
    chk("t4_gnt1", gnt1, 1);
    req1 = 0;
    tick();
    chk("t4_done_id", done_id, 1);
    chk("t4_sum", res_sum, 5);
    chk("t4_mult", res_mult, 6);
    tick();

    // contention held from reset: grants alternate 0,1,0,1, done every 3 cycles
    rst = 1;
    req0 = 1; a0 = 1; b0 = 2; req1 = 1; a1 = 3; b1 = 4;
    tick();
    tick();
    rst = 0;
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    last_done = -1;
    n_grants = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (gnt0 || gnt1) begin
        n_grants++;
        if (exp_q.size() == 0) chk("t5_extra_grant", 1, 0);
        else chk("t5_grant_order", gnt1, exp_q.pop_front());
      end
      if (done) begin
        if (last_done >= 0) chk("t5_done_spacing", i - last_done, 3);
        last_done = i;
      end
    end
    chk("t5_grant_count", n_grants, 4);
    req0 = 0; req1 = 0;
    tick();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: SEL_W, 4, ALU operation-select width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-006 a0, b0, a1, b1  input  DATA_W each  operands from requester 0 / 1.
REQ-007 cin0, cin1  input  1 each  carry-in; sel0, sel1  input  SEL_W each  operation select.
REQ-008 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands consumed.
REQ-009 alu_a, alu_b  output  DATA_W; alu_cin  output  1; alu_sel  output  SEL_W  drive the shared ALU.
REQ-010 alu_sum, alu_mult  input  DATA_W; alu_cout, alu_flag  input  1  combinational ALU results.
REQ-011 done  output  1  one-cycle result-valid pulse; done_id  output  1  requester owning result.
REQ-012 res_sum, res_mult  output  DATA_W; res_cout, res_flag  output  1  registered results.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: any req high at edge -> latch winner's a/b/cin/sel into operand regs, record winner id, go EXEC; no req -> stay IDLE.
REQ-016 gnt of winner high exactly during the EXEC cycle; never both gnt high.
REQ-017 EXEC: alu_a/alu_b/alu_cin/alu_sel driven from operand regs; at next edge capture alu_sum/alu_mult/alu_cout/alu_flag into res_*, go RESP.
REQ-018 Outside EXEC: alu_sel = 0, alu_a/alu_b/alu_cin hold operand regs.
REQ-019 RESP: done=1, done_id=winner; next edge go IDLE unconditionally.
REQ-020 Latency: req sampled at edge N -> gnt during cycle N..N+1 -> done during cycle N+1..N+2; earliest next accept at edge N+3 (one op per 3 cycles).
REQ-021 Round-robin: priority pointer resets to requester 0; on each grant pointer moves to the non-granted requester.
REQ-022 Both req high in IDLE -> requester named by pointer wins; loser must hold req, served next.
REQ-023 Single req -> served regardless of pointer; pointer still updates.
REQ-024 req changes during EXEC/RESP ignored; requester must keep req high until gnt; req dropped before acceptance is not served.
REQ-025 sel passed unmodified, including values >= 8; block never interprets sel.
REQ-026 res_* hold value until next EXEC capture; done_id holds last winner.
REQ-027 Data path pure pass-through: no truncation, extension or arithmetic on operands or results.

Reset
REQ-028 rst high: state IDLE, pointer=0, operand regs, res_*, done_id = 0; gnt0/gnt1/done/busy = 0; alu_* = 0.
REQ-029 rst mid-EXEC or mid-RESP aborts operation: no done pulse, no result capture, no pointer update.
REQ-030 First edge after rst release evaluates req in IDLE normally.

Structure
REQ-031 Shared package alu_pkg holds DATA_W/SEL_W defaults and FSM state enum (IDLE, EXEC, RESP).
REQ-032 One sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], pointer, update) -> one-hot grant; FSM/datapath in alu_arbiter.

Verification
REQ-033 Bench ALU stub: sum=a+b+cin (low DATA_W), cout=carry, mult=low DATA_W of a*b, flag=sum[DATA_W-1].
REQ-034 Single request: req0, a0=5, b0=7, cin0=1, sel0=1 -> gnt0 one cycle later, done next cycle, done_id=0, res_sum=13, res_mult=35, res_cout=0.
REQ-035 Contention: req0, req1 held from reset -> grant order 0,1,0,1; done every 3 cycles; gnt never simultaneous.
REQ-036 Wrap: a1=32'hFFFFFFFF, b1=1, cin1=0 -> res_sum=0, res_cout=1, res_flag=0, res_mult=32'hFFFFFFFF.
REQ-037 Reset mid-op: assert rst during EXEC -> no done, busy=0 immediately, res_* = 0; next req served normally, done_id correct.
REQ-038 Hold check: change a0 to 99 during EXEC -> result reflects latched operands; alu_sel=0 in IDLE/RESP, sel0=15 passed in EXEC.
